gb_boot_overlay: RTL and testbench
==================================

// Module: gb_boot_overlay
// PURPOSE
// - CPU-side bus sequencer directly upstream of gb_bootrom; it feeds that block its address, read strobe and hide-register write.
// - Maps 0x0000-0x00FF to the boot ROM while boot_hide=0, otherwise to the cartridge.
// - Decodes writes to 0xFF50 into the boot ROM's write_reg pulse.
// - Sequences each CPU read/write into a one-cycle acknowledge with returned data.
// PARAMETERS
// - CART_TIMEOUT  15     max cycles cart_rd stays high awaiting cart_ready; 1..255
// - OPEN_BUS      8'hFF  data returned on cartridge timeout
// PORTS
// - clk             in   1   system clock, all state on rising edge
// - reset_n         in   1   asynchronous, active-low reset
// - cpu_adr         in   16  CPU address, stable while cpu_rd/cpu_wr high
// - cpu_rd          in   1   read request level, held until cpu_ack
// - cpu_wr          in   1   write request level, held until cpu_ack
// - cpu_dout        in   8   CPU write data
// - cpu_din         out  8   read data, valid in the cpu_ack cycle
// - cpu_ack         out  1   one-cycle completion pulse
// - boot_adr        out  8   to gb_bootrom adr
// - boot_read       out  1   to gb_bootrom read; ROM samples on its rising edge
// - boot_dout       in   8   from gb_bootrom dout
// - boot_write_reg  out  1   to gb_bootrom write_reg, one-cycle pulse
// - boot_hide       in   1   from gb_bootrom r_hide
// - cart_adr        out  16  cartridge address
// - cart_rd         out  1   cartridge read request
// - cart_wr         out  1   cartridge write, one-cycle pulse
// - cart_dout       out  8   cartridge write data
// - cart_din        in   8   cartridge read data
// - cart_ready      in   1   cartridge data valid
// BEHAVIOUR
// - Reset values: cpu_din=8'h00; boot_adr=8'h00; cart_adr=16'h0000; cart_dout=8'h00.
// - All other outputs reset to 0; FSM resets to IDLE.
// - Reset is honoured mid-transaction: state is dropped and no ack is issued.
// - FSM states: IDLE, B_ADR, B_STB, B_CAP, C_WAIT, ACK.
// - IDLE: request sampled. cpu_wr has priority when cpu_rd and cpu_wr are both high.
//   - Write to 0xFF50 with cpu_dout!=0 and boot_hide=0: boot_write_reg=1 for one cycle, then ACK.
//   - Any other write to 0xFF50: ignored, then ACK.
//   - Write to any other address: cart_wr=1 for one cycle, cart_adr/cart_dout latched, then ACK.
//   - Read of 0x0000-0x00FF with boot_hide=0: boot_adr<=cpu_adr[7:0], go to B_ADR.
//   - Read of 0xFF50: cpu_din per GB_BOOT_READBACK_EN, then ACK.
//   - Any other read: cart_adr latched, cart_rd=1, go to C_WAIT; timeout counter cleared.
// - B_ADR: address settles; boot_read=0. Next state B_STB.
// - B_STB: boot_read=1 (rising edge reaches ROM). Next state B_CAP.
// - B_CAP: boot_read stays 1; cpu_din<=boot_dout; boot_read drops on exit. Next state ACK.
// - C_WAIT: counter increments each cycle.
//   - cart_ready=1: cpu_din<=cart_din, cart_rd<=0, go to ACK.
//   - Counter reaches CART_TIMEOUT without cart_ready: cpu_din<=OPEN_BUS, cart_rd<=0, go to ACK.
//   - cart_ready on the same cycle as the timeout: ready wins.
// - ACK: cpu_ack=1 for exactly one cycle, then IDLE.
//   - A request still high in IDLE is treated as a new transaction; the CPU must drop it after ack.
// - Latency from IDLE sample to cpu_ack:
//   - boot ROM read: 4 cycles
//   - register/write: 2 cycles
//   - cartridge read: 2+n cycles, where n = cycles until ready or timeout
// - boot_hide is sampled only in IDLE. A hide change in flight does not alter the current transaction.
// - Counter width is 8 bits; it saturates and never wraps.
// CONFIGURATION
// - GB_BOOT_READBACK_EN defined: a read of 0xFF50 returns {7'h7F, boot_hide}.
// - GB_BOOT_READBACK_EN undefined: a read of 0xFF50 returns 8'hFF.
// - Address 0xFF50 is never forwarded to the cartridge in either build.
// TESTING
// - Reset, boot_hide=0, read 0x0005, ROM[5]=8'h31 -> boot_read rises 2 cycles after sample; cpu_din=8'h31 with cpu_ack 4 cycles after sample; cart_rd stays 0.
// - Write 8'h01 to 0xFF50 -> one boot_write_reg pulse, then ack; after boot_hide=1, read 0x0005 -> cart_rd=1, cart_adr=16'h0005.
// - Write 8'h00 to 0xFF50 -> no boot_write_reg pulse, no cart_wr, ack after 2 cycles.
// - Read 0x4000 with cart_ready held low -> cart_rd high for 15 cycles; cpu_din=8'hFF on ack.
// - Assert reset_n=0 during B_STB -> all outputs return to reset values immediately; no cpu_ack is issued.
// - Read 0xFF50 with boot_hide=1 -> 8'hFF when GB_BOOT_READBACK_EN is defined; 8'hFF when it is undefined.
// - Read 0xFF50 with boot_hide=0 -> 8'hFE when GB_BOOT_READBACK_EN is defined; 8'hFF when it is undefined.

Source files
------------

// File: rtl/gb_boot_overlay_if.sv
// rtl/gb_boot_overlay_if.sv - CPU request/acknowledge bus between the CPU and gb_boot_overlay
interface gb_boot_overlay_if;
   logic [15:0] cpu_adr;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        cpu_ack;

   modport master (
      output cpu_adr, cpu_rd, cpu_wr, cpu_dout,
      input  cpu_din, cpu_ack
   );

   modport slave (
      input  cpu_adr, cpu_rd, cpu_wr, cpu_dout,
      output cpu_din, cpu_ack
   );
endinterface

// File: rtl/gb_boot_overlay.sv
// rtl/gb_boot_overlay.sv - boot ROM overlay and CPU bus sequencer in front of gb_bootrom
// Optional feature macro: GB_BOOT_READBACK_EN (0xFF50 reads return {7'h7F, boot_hide})
module gb_boot_overlay #(
   parameter int unsigned CART_TIMEOUT = 15,
   parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
   input  logic             clk,
   input  logic             reset_n,
   gb_boot_overlay_if.slave cpu,
   output logic [7:0]       boot_adr,
   output logic             boot_read,
   input  logic [7:0]       boot_dout,
   output logic             boot_write_reg,
   input  logic             boot_hide,
   output logic [15:0]      cart_adr,
   output logic             cart_rd,
   output logic             cart_wr,
   output logic [7:0]       cart_dout,
   input  logic [7:0]       cart_din,
   input  logic             cart_ready
);

   localparam logic [15:0] HIDE_REG_ADR = 16'hFF50;
   localparam logic [7:0]  TIMEOUT_CNT  = 8'(CART_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      B_ADR  = 3'd1,
      B_STB  = 3'd2,
      B_CAP  = 3'd3,
      C_WAIT = 3'd4,
      ACK    = 3'd5
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic       ack_hold;
   logic [7:0] readback;
   logic       is_wr;
   logic       is_rd;
   logic       hit_reg;
   logic       hit_boot;
   logic       cnt_last;

`ifdef GB_BOOT_READBACK_EN
   assign readback = {7'h7F, boot_hide};
`else
   assign readback = 8'hFF;
`endif

   // Request decode; writes win over reads, hide only matters for the low page
   always_comb begin
      is_wr    = cpu.cpu_wr;
      is_rd    = cpu.cpu_rd & ~cpu.cpu_wr;
      hit_reg  = (cpu.cpu_adr == HIDE_REG_ADR);
      hit_boot = (cpu.cpu_adr[15:8] == 8'h00) & ~boot_hide;
      cnt_last = ({1'b0, cnt} + 9'd1) >= {1'b0, TIMEOUT_CNT};
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded strobes; ack_hold gives register/write paths their settle cycle
   always_comb begin
      state_nxt   = state;
      boot_read   = 1'b0;
      cpu.cpu_ack = 1'b0;
      case (state)
         IDLE: begin
            if (is_wr) begin
               state_nxt = ACK;
            end else if (is_rd) begin
               if (hit_boot) begin
                  state_nxt = B_ADR;
               end else if (hit_reg) begin
                  state_nxt = ACK;
               end else begin
                  state_nxt = C_WAIT;
               end
            end
         end
         B_ADR: begin
            state_nxt = B_STB;
         end
         B_STB: begin
            boot_read = 1'b1;
            state_nxt = B_CAP;
         end
         B_CAP: begin
            boot_read = 1'b1;
            state_nxt = ACK;
         end
         C_WAIT: begin
            if (cart_ready || cnt_last) begin
               state_nxt = ACK;
            end
         end
         ACK: begin
            cpu.cpu_ack = ~ack_hold;
            if (!ack_hold) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered datapath: address/data latches, write pulses, cart wait counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu.cpu_din    <= 8'h00;
         boot_adr       <= 8'h00;
         boot_write_reg <= 1'b0;
         cart_adr       <= 16'h0000;
         cart_dout      <= 8'h00;
         cart_rd        <= 1'b0;
         cart_wr        <= 1'b0;
         cnt            <= 8'h00;
         ack_hold       <= 1'b0;
      end else begin
         boot_write_reg <= 1'b0;
         cart_wr        <= 1'b0;
         case (state)
            IDLE: begin
               if (is_wr) begin
                  ack_hold <= 1'b1;
                  if (hit_reg) begin
                     boot_write_reg <= (cpu.cpu_dout != 8'h00) & ~boot_hide;
                  end else begin
                     cart_wr   <= 1'b1;
                     cart_adr  <= cpu.cpu_adr;
                     cart_dout <= cpu.cpu_dout;
                  end
               end else if (is_rd) begin
                  if (hit_boot) begin
                     boot_adr <= cpu.cpu_adr[7:0];
                  end else if (hit_reg) begin
                     cpu.cpu_din <= readback;
                     ack_hold    <= 1'b1;
                  end else begin
                     cart_adr <= cpu.cpu_adr;
                     cart_rd  <= 1'b1;
                     cnt      <= 8'h00;
                  end
               end
            end
            B_CAP: begin
               cpu.cpu_din <= boot_dout;
            end
            C_WAIT: begin
               if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
               if (cart_ready) begin
                  cpu.cpu_din <= cart_din;
                  cart_rd     <= 1'b0;
               end else if (cnt_last) begin
                  cpu.cpu_din <= OPEN_BUS;
                  cart_rd     <= 1'b0;
               end
            end
            ACK: begin
               ack_hold <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gb_boot_overlay.sv
// tb/tb_gb_boot_overlay.sv - self-checking bench for gb_boot_overlay
`timescale 1ns/1ps
module tb_gb_boot_overlay;
   localparam int CART_TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  boot_adr;
   logic        boot_read;
   logic [7:0]  boot_dout;
   logic        boot_write_reg;
   logic        boot_hide;
   logic [15:0] cart_adr;
   logic        cart_rd;
   logic        cart_wr;
   logic [7:0]  cart_dout;
   logic [7:0]  cart_din;
   logic        cart_ready;

   always #5 clk = ~clk;

   gb_boot_overlay_if cpu ();

   gb_boot_overlay #(.CART_TIMEOUT(CART_TIMEOUT), .OPEN_BUS(8'hFF)) dut (
      .clk(clk), .reset_n(reset_n), .cpu(cpu),
      .boot_adr(boot_adr), .boot_read(boot_read), .boot_dout(boot_dout),
      .boot_write_reg(boot_write_reg), .boot_hide(boot_hide),
      .cart_adr(cart_adr), .cart_rd(cart_rd), .cart_wr(cart_wr),
      .cart_dout(cart_dout), .cart_din(cart_din), .cart_ready(cart_ready)
   );

   // boot ROM model: contents i ^ 0x34, sampled on the rising edge of read
   logic [7:0] rom [256];
   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h34;
      boot_dout = 8'h00;
   end
   always @(posedge boot_read) boot_dout <= rom[boot_adr];

   // hide register model: set by a write_reg pulse, cleared by reset
   always @(posedge clk or negedge reset_n)
      if (!reset_n) boot_hide <= 1'b0;
      else if (boot_write_reg) boot_hide <= 1'b1;

   // cartridge model: ready in the (cart_delay+1)-th cycle of cart_rd
   int cart_delay = 0;
   int cart_hi = 0;
   always @(negedge clk) cart_hi = cart_rd ? cart_hi + 1 : 0;
   assign cart_ready = cart_rd && (cart_hi >= cart_delay + 1);
   assign cart_din   = cart_adr[7:0] ^ 8'hA5;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        txn_active = 1'b0;
   int          t0 = 0;
   int          exp_lat = 0;
   int          exp_cart_hi = 0;
   logic        exp_wr = 1'b0, exp_boot = 1'b0, exp_bwr = 1'b0, exp_cwr = 1'b0, exp_cart = 1'b0;
   logic [7:0]  exp_data = 8'h00, exp_badr = 8'h00, exp_cdout = 8'h00;
   logic [15:0] exp_cadr = 16'h0000;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // transaction-level model: outcome, latency and strobe windows from the address map rules
   task automatic plan(input logic rd, input logic wr, input logic [15:0] adr, input logic [7:0] dat, input int delay);
      logic [7:0] rb;
`ifdef GB_BOOT_READBACK_EN
      rb = {7'h7F, boot_hide};
`else
      rb = 8'hFF;
`endif
      exp_wr = wr; exp_boot = 0; exp_bwr = 0; exp_cwr = 0; exp_cart = 0; exp_cart_hi = 0;
      exp_data = 8'h00; exp_cadr = adr; exp_badr = adr[7:0]; exp_cdout = dat; exp_lat = 2;
      if (wr) begin
         if (adr == 16'hFF50) exp_bwr = (dat != 8'h00) && !boot_hide;
         else exp_cwr = 1'b1;
      end else if (rd && adr < 16'h0100 && !boot_hide) begin
         exp_boot = 1'b1; exp_lat = 4; exp_data = rom[adr[7:0]];
      end else if (rd && adr == 16'hFF50) begin
         exp_data = rb;
      end else begin
         exp_cart = 1'b1;
         if (delay + 1 <= CART_TIMEOUT) begin
            exp_cart_hi = delay + 1; exp_data = adr[7:0] ^ 8'hA5;
         end else begin
            exp_cart_hi = CART_TIMEOUT; exp_data = 8'hFF;
         end
         exp_lat = exp_cart_hi + 1;
      end
   endtask

   // per-cycle comparison of DUT strobes and data against the model
   always @(negedge clk) begin
      int rel;
      logic e_ack, e_br, e_bw, e_cw, e_cr;
      rel   = txn_active ? (cyc - t0 + 1) : 0;
      e_ack = txn_active && (rel == exp_lat);
      e_br  = txn_active && exp_boot && (rel == 2 || rel == 3);
      e_bw  = txn_active && exp_bwr && (rel == 1);
      e_cw  = txn_active && exp_cwr && (rel == 1);
      e_cr  = txn_active && exp_cart && (rel >= 1) && (rel <= exp_cart_hi);
      chk("cpu_ack", 16'(cpu.cpu_ack), 16'(e_ack));
      chk("boot_read", 16'(boot_read), 16'(e_br));
      chk("boot_write_reg", 16'(boot_write_reg), 16'(e_bw));
      chk("cart_wr", 16'(cart_wr), 16'(e_cw));
      chk("cart_rd", 16'(cart_rd), 16'(e_cr));
      if (e_ack && !exp_wr) chk("cpu_din", 16'(cpu.cpu_din), 16'(exp_data));
      if (e_cw) begin
         chk("cart_adr_wr", cart_adr, exp_cadr);
         chk("cart_dout", 16'(cart_dout), 16'(exp_cdout));
      end
      if (e_cr) chk("cart_adr_rd", cart_adr, exp_cadr);
      if (e_br) chk("boot_adr", 16'(boot_adr), 16'(exp_badr));
   end

   task automatic run(input logic rd, input logic wr, input logic [15:0] adr, input logic [7:0] dat,
                      input int delay, output int lat, output logic [7:0] din, output int hi,
                      output int br, output int pw);
      @(posedge clk); #1;
      cart_delay = delay;
      plan(rd, wr, adr, dat, delay);
      cpu.cpu_adr = adr; cpu.cpu_rd = rd; cpu.cpu_wr = wr; cpu.cpu_dout = dat;
      t0 = cyc + 1; txn_active = 1'b1;
      lat = -1; din = 8'h00; hi = 0; br = -1; pw = 0;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(negedge clk);
         if (cart_rd) hi++;
         if (boot_write_reg || cart_wr) pw++;
         if (boot_read && br < 0) br = cyc - t0 + 1;
         if (cpu.cpu_ack) begin
            lat = cyc - t0 + 1; din = cpu.cpu_din;
         end
      end
      if (lat < 0) begin
         checks++; errors++;
         $display("FAIL ack_timeout: no cpu_ack within 40 cycles for adr %h", adr);
      end
      @(posedge clk); #1;
      cpu.cpu_rd = 1'b0; cpu.cpu_wr = 1'b0; txn_active = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cpu_din"}, 16'(cpu.cpu_din), 16'h0000);
      chk({tag, "_cpu_ack"}, 16'(cpu.cpu_ack), 16'h0000);
      chk({tag, "_boot_adr"}, 16'(boot_adr), 16'h0000);
      chk({tag, "_boot_read"}, 16'(boot_read), 16'h0000);
      chk({tag, "_boot_write_reg"}, 16'(boot_write_reg), 16'h0000);
      chk({tag, "_cart_adr"}, cart_adr, 16'h0000);
      chk({tag, "_cart_rd"}, 16'(cart_rd), 16'h0000);
      chk({tag, "_cart_wr"}, 16'(cart_wr), 16'h0000);
      chk({tag, "_cart_dout"}, 16'(cart_dout), 16'h0000);
   endtask

   initial begin
      int lat, hi, br, pw;
      logic [7:0] din;
      cpu.cpu_adr = 16'h0000; cpu.cpu_rd = 1'b0; cpu.cpu_wr = 1'b0; cpu.cpu_dout = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset_n = 1'b1;

      run(1, 0, 16'h0005, 8'h00, 0, lat, din, hi, br, pw);
      chk("boot5_lat", 16'(lat), 16'd4);
      chk("boot5_data", 16'(din), 16'h0031);
      chk("boot5_read_rise", 16'(br), 16'd2);
      chk("boot5_cart_rd", 16'(hi), 16'd0);

      run(1, 0, 16'h00FF, 8'h00, 0, lat, din, hi, br, pw);
      chk("bootff_data", 16'(din), 16'h00CB);

      run(1, 0, 16'hFF50, 8'h00, 0, lat, din, hi, br, pw);
`ifdef GB_BOOT_READBACK_EN
      chk("rb_hide0", 16'(din), 16'h00FE);
`else
      chk("rb_hide0", 16'(din), 16'h00FF);
`endif
      chk("rb_lat", 16'(lat), 16'd2);

      run(0, 1, 16'hFF50, 8'h00, 0, lat, din, hi, br, pw);
      chk("wr0_lat", 16'(lat), 16'd2);
      chk("wr0_pulses", 16'(pw), 16'd0);
      chk("wr0_hide", 16'(boot_hide), 16'd0);

      run(0, 1, 16'h1234, 8'h5A, 0, lat, din, hi, br, pw);
      chk("cwr_pulses", 16'(pw), 16'd1);

      run(1, 0, 16'h4000, 8'h00, 255, lat, din, hi, br, pw);
      chk("tmo_hi", 16'(hi), 16'd15);
      chk("tmo_data", 16'(din), 16'h00FF);
      chk("tmo_lat", 16'(lat), 16'd16);

      run(1, 0, 16'h4001, 8'h00, 0, lat, din, hi, br, pw);
      chk("cart0_data", 16'(din), 16'h00A4);
      chk("cart0_lat", 16'(lat), 16'd2);

      run(1, 0, 16'h8002, 8'h00, 14, lat, din, hi, br, pw);
      chk("cart_edge_data", 16'(din), 16'h00A7);
      chk("cart_edge_hi", 16'(hi), 16'd15);

      run(1, 0, 16'h4003, 8'h00, 3, lat, din, hi, br, pw);
      chk("cart3_lat", 16'(lat), 16'd5);

      // reset while the ROM strobe is high
      @(posedge clk); #1;
      plan(1, 0, 16'h0010, 8'h00, 0);
      cpu.cpu_adr = 16'h0010; cpu.cpu_rd = 1'b1;
      t0 = cyc + 1; txn_active = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("pre_reset_boot_read", 16'(boot_read), 16'd1);
      reset_n = 1'b0; txn_active = 1'b0; cpu.cpu_rd = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      run(0, 1, 16'hFF50, 8'h01, 0, lat, din, hi, br, pw);
      chk("wr1_pulses", 16'(pw), 16'd1);
      chk("wr1_lat", 16'(lat), 16'd2);
      chk("wr1_hide", 16'(boot_hide), 16'd1);

      run(1, 0, 16'h0005, 8'h00, 2, lat, din, hi, br, pw);
      chk("hidden5_hi", 16'(hi), 16'd3);
      chk("hidden5_data", 16'(din), 16'h00A0);
      chk("hidden5_adr", cart_adr, 16'h0005);

      run(1, 0, 16'hFF50, 8'h00, 0, lat, din, hi, br, pw);
      chk("rb_hide1", 16'(din), 16'h00FF);

      run(0, 1, 16'hFF50, 8'h01, 0, lat, din, hi, br, pw);
      chk("wr_hidden_pulses", 16'(pw), 16'd0);

      run(1, 1, 16'h2000, 8'h77, 0, lat, din, hi, br, pw);
      chk("prio_hi", 16'(hi), 16'd0);
      chk("prio_pulses", 16'(pw), 16'd1);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
